// File: rtl/tqvp_stevej_watchdog_multi.sv
// Multi-channel windowed watchdog on the TinyQV peripheral bus: shared prescaler, per-channel window timers, W1C irq status.
// Optional macro WDOG_PAT_KEY_EN: a PAT write must carry 8'hA5 in data_in[7:0], otherwise the channel faults.
module tqvp_stevej_watchdog_multi #(
    parameter int NUM_CH     = 2,
    parameter int TIMER_W    = 24,
    parameter int PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLOSED  = 3'd1;
    localparam logic [2:0] ST_OPEN    = 3'd2;
    localparam logic [2:0] ST_EXPIRED = 3'd3;
    localparam logic [2:0] ST_FAULT   = 3'd4;

    localparam logic [5:0] ADDR_PRESCALE = 6'h10;
    localparam logic [5:0] ADDR_IRQ      = 6'h11;
    localparam logic [5:0] ADDR_UI       = 6'h12;

    logic wr_en;
    assign wr_en = (data_write_n != 2'b11);

    logic pat_key_ok;
`ifdef WDOG_PAT_KEY_EN
    assign pat_key_ok = (data_in[7:0] == 8'hA5);
`else
    assign pat_key_ok = 1'b1;
`endif

    // Shared prescaler: lowering PRESCALE below the running count lets the counter wrap once.
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] presc_cnt;
    logic                  tick;

    assign tick = (presc_cnt == prescale);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescale  <= '0;
            presc_cnt <= '0;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + PRESCALE_W'(1);
            if (wr_en && address == ADDR_PRESCALE) begin
                prescale <= data_in[PRESCALE_W-1:0];
            end
        end
    end

    logic [NUM_CH-1:0]       pending;
    logic [NUM_CH-1:0]       pend_set;
    logic [NUM_CH-1:0]       fail;
    logic [NUM_CH-1:0]       irq_en_vec;
    logic [NUM_CH-1:0][31:0] ctrl_rd;
    logic [NUM_CH-1:0][31:0] open_rd;
    logic [NUM_CH-1:0][31:0] close_rd;
    logic [NUM_CH-1:0][31:0] timer_rd;

    generate
        for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
            localparam logic [5:0] BASE = 6'(4 * n);

            logic               wr_ctrl;
            logic               wr_open;
            logic               wr_close;
            logic               wr_pat;
            logic               enable;
            logic               early_fault_en;
            logic               irq_en;
            logic [TIMER_W-1:0] win_open;
            logic [TIMER_W-1:0] win_close;
            logic [TIMER_W-1:0] timer;
            logic [TIMER_W-1:0] timer_inc;
            logic [TIMER_W-1:0] timer_nxt;
            logic [2:0]         state;
            logic [2:0]         state_nxt;
            logic [7:0]         pat_count;
            logic [7:0]         pat_count_nxt;
            logic               active;
            logic               is_fail;

            assign wr_ctrl  = wr_en && (address == BASE);
            assign wr_open  = wr_en && (address == BASE + 6'd1);
            assign wr_close = wr_en && (address == BASE + 6'd2);
            assign wr_pat   = wr_en && (address == BASE + 6'd3);

            assign active    = (state == ST_CLOSED) || (state == ST_OPEN);
            assign is_fail   = (state == ST_EXPIRED) || (state == ST_FAULT);
            assign timer_inc = (&timer) ? timer : timer + TIMER_W'(1);

            // Priority: disable, enable from IDLE, pat, then tick; a pat therefore beats a coincident tick.
            always_comb begin
                state_nxt     = state;
                timer_nxt     = timer;
                pat_count_nxt = pat_count;
                if (wr_ctrl && !data_in[0]) begin
                    state_nxt = ST_IDLE;
                    timer_nxt = '0;
                end else if (wr_ctrl && state == ST_IDLE) begin
                    state_nxt     = ST_CLOSED;
                    timer_nxt     = '0;
                    pat_count_nxt = '0;
                end else if (wr_pat && active) begin
                    if (!pat_key_ok || (state == ST_CLOSED && early_fault_en)) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        state_nxt = ST_CLOSED;
                        timer_nxt = '0;
                        if (pat_count != 8'hFF) begin
                            pat_count_nxt = pat_count + 8'd1;
                        end
                    end
                end else if (tick && active) begin
                    timer_nxt = timer_inc;
                    if (timer_inc > win_close) begin
                        state_nxt = ST_EXPIRED;
                    end else if (timer_inc > win_open) begin
                        state_nxt = ST_OPEN;
                    end else begin
                        state_nxt = ST_CLOSED;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    enable         <= 1'b0;
                    early_fault_en <= 1'b0;
                    irq_en         <= 1'b0;
                    win_open       <= '0;
                    win_close      <= '0;
                    timer          <= '0;
                    state          <= ST_IDLE;
                    pat_count      <= '0;
                end else begin
                    state     <= state_nxt;
                    timer     <= timer_nxt;
                    pat_count <= pat_count_nxt;
                    if (wr_ctrl) begin
                        enable         <= data_in[0];
                        early_fault_en <= data_in[1];
                        irq_en         <= data_in[2];
                    end
                    if (wr_open && state == ST_IDLE) begin
                        win_open <= data_in[TIMER_W-1:0];
                    end
                    if (wr_close && state == ST_IDLE) begin
                        win_close <= data_in[TIMER_W-1:0];
                    end
                end
            end

            assign pend_set[n]   = ((state_nxt == ST_EXPIRED) || (state_nxt == ST_FAULT)) && !is_fail;
            assign fail[n]       = is_fail;
            assign irq_en_vec[n] = irq_en;
            assign ctrl_rd[n]    = {16'h0000, pat_count, 1'b0, state, 1'b0, irq_en, early_fault_en, enable};
            assign open_rd[n]    = 32'(win_open);
            assign close_rd[n]   = 32'(win_close);
            assign timer_rd[n]   = 32'(timer);
        end
    endgenerate

    logic [NUM_CH-1:0] w1c;
    assign w1c = (wr_en && address == ADDR_IRQ) ? data_in[NUM_CH-1:0] : '0;

    // A fresh failure wins over a same-cycle clear so it can never be lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~w1c) | pend_set;
        end
    end

    assign user_interrupt = |(pending & irq_en_vec);
    assign data_ready     = 1'b1;

    logic [3:0] fail_pad;
    logic       any_fail;

    always_comb begin
        fail_pad             = '0;
        fail_pad[NUM_CH-1:0] = fail;
    end

    assign any_fail = |fail;
    assign uo_out   = {any_fail, ~any_fail, fail_pad, 2'b00};

    always_comb begin
        data_out = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (address == 6'(4 * n))     data_out = ctrl_rd[n];
            if (address == 6'(4 * n + 1)) data_out = open_rd[n];
            if (address == 6'(4 * n + 2)) data_out = close_rd[n];
            if (address == 6'(4 * n + 3)) data_out = timer_rd[n];
        end
        case (address)
            ADDR_PRESCALE: data_out = 32'(prescale);
            ADDR_IRQ:      data_out = 32'(pending);
            ADDR_UI:       data_out = {24'h000000, ui_in};
            default:       ;
        endcase
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, data_read_n, data_in};

endmodule

// File: tb/tb_tqvp_stevej_watchdog_multi.sv
// Scoreboard bench for the multi-channel watchdog: expectations queued at stimulus time, popped at each sample point.
module tb_tqvp_stevej_watchdog_multi;
    localparam int          NUM_CH  = 3;
    localparam int          TIMER_W = 8;
    localparam logic [31:0] PAT_KEY = 32'h0000_00A5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got;
    logic [31:0] exp;

    always #5 clk = ~clk;

    tqvp_stevej_watchdog_multi #(
        .NUM_CH    (NUM_CH),
        .TIMER_W   (TIMER_W),
        .PRESCALE_W(8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ui_in         (ui_in),
        .uo_out        (uo_out),
        .address       (address),
        .data_in       (data_in),
        .data_write_n  (data_write_n),
        .data_read_n   (data_read_n),
        .data_out      (data_out),
        .data_ready    (data_ready),
        .user_interrupt(user_interrupt)
    );

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        address      = a;
        data_in      = d;
        data_write_n = 2'b10;
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = data_out;
    endtask

    task automatic pat_when(input logic [5:0] base, input logic [31:0] val, input int budget, output bit ok);
        logic [31:0] t;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            bus_read(base + 6'd3, t);
            if (t == val) begin
                data_in      = PAT_KEY;
                data_write_n = 2'b10;
                @(negedge clk);
                data_write_n = 2'b11;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_timer_step(input logic [5:0] base, input int budget, output bit ok, output logic [31:0] v);
        logic [31:0] prev;
        logic [31:0] t;
        ok = 1'b0;
        bus_read(base + 6'd3, prev);
        v = prev;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            bus_read(base + 6'd3, t);
            if (t != prev) begin
                v  = t;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        got = {24'h0, uo_out};
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL reset_uo_out: got %0h expected %0h", got, exp); end
        got = {31'h0, user_interrupt};
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL reset_irq: got %0h expected %0h", got, exp); end
        got = {31'h0, data_ready};
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL data_ready: got %0h expected %0h", got, exp); end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0000_005A);
        bus_read(6'h11, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL reset_irq_status: got %0h expected %0h", got, exp); end
        bus_read(6'h12, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL ui_in_readback: got %0h expected %0h", got, exp); end
    endtask

    task automatic test_absent_channel();
        bus_write(6'd12, 32'h1);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h40);
        bus_read(6'd12, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL absent_ctrl: got %0h expected %0h", got, exp); end
        bus_read(6'h20, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL unmapped_read: got %0h expected %0h", got, exp); end
        got = {24'h0, uo_out};
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL absent_uo_out: got %0h expected %0h", got, exp); end
    endtask

    task automatic test_window_pat();
        bit ok;
        bus_write(6'd1, 32'd10);
        bus_write(6'd2, 32'd20);
        bus_write(6'd0, 32'h5);
        pat_when(6'd0, 32'd15, 40, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL win_pat_timeout: got timer never 15 expected 15"); end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h115);
        bus_read(6'd3, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL win_timer_after_pat: got %0h expected %0h", got, exp); end
        bus_read(6'd0, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL win_ctrl_after_pat: got %0h expected %0h", got, exp); end
        repeat (20) @(negedge clk);
        exp_q.push_back(32'h125);
        exp_q.push_back(32'd20);
        bus_read(6'd0, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL win_open_at_20: got %0h expected %0h", got, exp); end
        bus_read(6'd3, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL win_timer_20: got %0h expected %0h", got, exp); end
        @(negedge clk);
        exp_q.push_back(32'h135);
        exp_q.push_back(32'd21);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h84);
        exp_q.push_back(32'h1);
        bus_read(6'd0, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL win_expired_at_21: got %0h expected %0h", got, exp); end
        bus_read(6'd3, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL win_timer_21: got %0h expected %0h", got, exp); end
        bus_read(6'h11, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL win_pending: got %0h expected %0h", got, exp); end
        got = {24'h0, uo_out};
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL win_uo_out: got %0h expected %0h", got, exp); end
        got = {31'h0, user_interrupt};
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL win_user_irq: got %0h expected %0h", got, exp); end
        repeat (3) @(negedge clk);
        exp_q.push_back(32'd21);
        bus_read(6'd3, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL win_timer_frozen: got %0h expected %0h", got, exp); end
        bus_write(6'd0, 32'h0);
        bus_write(6'h11, 32'h1);
    endtask

    task automatic test_early_fault();
        bit ok;
        bus_write(6'd5, 32'd10);
        bus_write(6'd6, 32'd20);
        bus_write(6'd4, 32'h7);
        pat_when(6'd4, 32'd5, 40, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL early_pat_timeout: got timer never 5 expected 5"); end
        exp_q.push_back(32'h047);
        bus_read(6'd4, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL early_fault_state: got %0h expected %0h", got, exp); end
        repeat (4) @(negedge clk);
        exp_q.push_back(32'd5);
        exp_q.push_back(32'h2);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h88);
        bus_read(6'd7, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL early_timer_hold: got %0h expected %0h", got, exp); end
        bus_read(6'h11, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL early_pending: got %0h expected %0h", got, exp); end
        got = {31'h0, user_interrupt};
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL early_user_irq: got %0h expected %0h", got, exp); end
        got = {24'h0, uo_out};
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL early_uo_out: got %0h expected %0h", got, exp); end
        bus_write(6'h11, 32'h2);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h047);
        got = {31'h0, user_interrupt};
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL w1c_user_irq: got %0h expected %0h", got, exp); end
        bus_read(6'h11, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL w1c_status: got %0h expected %0h", got, exp); end
        bus_read(6'd4, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL w1c_state_kept: got %0h expected %0h", got, exp); end
    endtask

    task automatic test_prescale_saturation();
        bit          ok;
        logic [31:0] v;
        int          bad;
        bus_write(6'h10, 32'd3);
        exp_q.push_back(32'd3);
        bus_read(6'h10, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL prescale_readback: got %0h expected %0h", got, exp); end
        bus_write(6'd9, 32'hFF);
        bus_write(6'd10, 32'hFF);
        bus_write(6'd8, 32'h1);
        wait_timer_step(6'd8, 10, ok, v);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL prescale_no_step: got no timer change expected a step within 10 cycles"); end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_read(6'd11, got);
            if (got != v) bad++;
        end
        exp_q.push_back(32'd0);
        exp = exp_q.pop_front(); n_cmp++;
        if (32'(bad) !== exp) begin n_err++; $display("FAIL prescale_hold: got %0d early steps expected %0d", bad, exp); end
        @(negedge clk);
        exp_q.push_back(v + 32'd1);
        bus_read(6'd11, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL prescale_step4: got %0h expected %0h", got, exp); end
        repeat (1100) @(negedge clk);
        exp_q.push_back(32'hFF);
        exp_q.push_back(32'h011);
        exp_q.push_back(32'h0);
        bus_read(6'd11, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL sat_timer: got %0h expected %0h", got, exp); end
        bus_read(6'd8, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL sat_no_expire: got %0h expected %0h", got, exp); end
        bus_read(6'h11, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL sat_pending: got %0h expected %0h", got, exp); end
    endtask

    task automatic test_locked_windows();
        bus_write(6'd9, 32'd7);
        exp_q.push_back(32'hFF);
        bus_read(6'd9, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL locked_open: got %0h expected %0h", got, exp); end
        bus_write(6'd8, 32'h0);
        bus_write(6'd9, 32'd7);
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'h000);
        bus_read(6'd9, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL unlocked_open: got %0h expected %0h", got, exp); end
        bus_read(6'd11, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL disable_timer: got %0h expected %0h", got, exp); end
        bus_read(6'd8, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL disable_ctrl: got %0h expected %0h", got, exp); end
    endtask

    task automatic test_back_to_back();
        bit          ok;
        logic [31:0] v;
        // pat landing on a prescaler tick edge
        bus_write(6'd1, 32'd2);
        bus_write(6'd2, 32'd200);
        bus_write(6'd0, 32'h1);
        wait_timer_step(6'd0, 10, ok, v);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL b2b_no_step: got no timer change expected a step within 10 cycles"); end
        repeat (3) @(negedge clk);
        address      = 6'd3;
        data_in      = PAT_KEY;
        data_write_n = 2'b10;
        @(negedge clk);
        data_write_n = 2'b11;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'h111);
        bus_read(6'd3, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL pat_beats_tick: got %0h expected %0h", got, exp); end
        bus_read(6'd0, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL pat_tick_ctrl: got %0h expected %0h", got, exp); end
        // expiry on the same edge as a W1C of that channel
        bus_write(6'h10, 32'd0);
        repeat (300) @(negedge clk);
        bus_write(6'd0, 32'h0);
        bus_write(6'd1, 32'd3);
        bus_write(6'd2, 32'd5);
        bus_write(6'd0, 32'h1);
        repeat (5) @(negedge clk);
        exp_q.push_back(32'h021);
        bus_read(6'd0, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL pre_expire_open: got %0h expected %0h", got, exp); end
        address      = 6'h11;
        data_in      = 32'h1;
        data_write_n = 2'b10;
        @(negedge clk);
        data_write_n = 2'b11;
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h031);
        bus_read(6'h11, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL set_beats_w1c: got %0h expected %0h", got, exp); end
        bus_read(6'd0, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL w1c_expired_state: got %0h expected %0h", got, exp); end
    endtask

`ifdef WDOG_PAT_KEY_EN
    task automatic test_pat_key();
        bus_write(6'h11, 32'h1);
        bus_write(6'd0, 32'h0);
        bus_write(6'd1, 32'd2);
        bus_write(6'd2, 32'd200);
        bus_write(6'd0, 32'h1);
        repeat (5) @(negedge clk);
        bus_write(6'd3, 32'h0);
        exp_q.push_back(32'h041);
        exp_q.push_back(32'h1);
        bus_read(6'd0, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL bad_key_fault: got %0h expected %0h", got, exp); end
        bus_read(6'h11, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL bad_key_pending: got %0h expected %0h", got, exp); end
        bus_write(6'h11, 32'h1);
        bus_write(6'd0, 32'h0);
        bus_write(6'd0, 32'h1);
        repeat (5) @(negedge clk);
        bus_write(6'd3, PAT_KEY);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'h111);
        bus_read(6'd3, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL good_key_timer: got %0h expected %0h", got, exp); end
        bus_read(6'd0, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL good_key_ctrl: got %0h expected %0h", got, exp); end
    endtask
`endif

    task automatic test_reset_mid();
        bus_write(6'd0, 32'h0);
        bus_write(6'd1, 32'd2);
        bus_write(6'd2, 32'd200);
        bus_write(6'd0, 32'h1);
        repeat (5) @(negedge clk);
        exp_q.push_back(32'h021);
        bus_read(6'd0, got);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL mid_open_before_reset: got %0h expected %0h", got, exp); end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a <= 17; a++) begin
            @(negedge clk);
            exp_q.push_back(32'h0);
            bus_read(6'(a), got);
            exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL reset_reg_%0h: got %0h expected %0h", a, got, exp); end
        end
        @(negedge clk);
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h0);
        got = {24'h0, uo_out};
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL mid_reset_uo_out: got %0h expected %0h", got, exp); end
        got = {31'h0, user_interrupt};
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL mid_reset_irq: got %0h expected %0h", got, exp); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish within 1 ms");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n        = 1'b0;
        ui_in        = 8'h5A;
        address      = 6'd0;
        data_in      = 32'h0;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_absent_channel();
        test_window_pat();
        test_early_fault();
        test_prescale_saturation();
        test_locked_windows();
        test_back_to_back();
`ifdef WDOG_PAT_KEY_EN
        test_pat_key();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
